// File: rtl/ahb_lite_master_port.sv
// Single-outstanding AHB-Lite initiator: turns one command into one SINGLE
// read/write transfer, handles wait states and the two-cycle ERROR response,
// and rejects misaligned or oversized commands without touching the bus.
module ahb_lite_master_port #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // Command / response side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // AHB-Lite initiator side
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StErr2} state_e;

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        cmd_bad;

  // Oversized or not naturally aligned commands are answered locally.
  always_comb begin
    cmd_bad = (cmd_size > 3'd2) ||
              ((cmd_size == 3'd1) && cmd_addr[0]) ||
              ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
  end

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      StIdle: begin
        htrans_d = TransIdle;
        if (cmd_valid) begin
          if (cmd_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            haddr_d  = cmd_addr;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            wdata_d  = cmd_wdata;
            htrans_d = TransNonseq;
            state_d  = StAddr;
          end
        end
      end
      StAddr: begin
        if (HREADY) begin
          htrans_d = TransIdle;
          if (hwrite_q) hwdata_d = wdata_q;
          state_d = StData;
        end
      end
      StData: begin
        if (HREADY) begin
          // HREADY=1 with HRESP=1 is not a legal single-cycle error; report it anyway.
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          rsp_rdata_d = (hwrite_q || HRESP) ? 32'h0 : HRDATA;
          state_d     = StIdle;
        end else if (HRESP) begin
          state_d = StErr2;
        end
      end
      StErr2: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any in-flight transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      haddr_q     <= '0;
      htrans_q    <= TransIdle;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Bench for ahb_lite_master_port: scenario tasks drive commands and a
// scripted slave; a monitor pops expected responses from a queue.
module tb_ahb_lite_master_port;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ahb_lite_master_port dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got rdata=%h err=%b with nothing expected",
                 rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err} !== {mon_e.rdata, mon_e.err}) begin
          errors++;
          $display("FAIL rsp_payload got rdata=%h err=%b exp rdata=%h err=%b",
                   rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  // Present one command for one edge; returns 1ns after the accepting edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    @(posedge HCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_wdata = 32'hBAD0_BAD0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    checks++;
    if ({HTRANS, HADDR, HWDATA, HSIZE, HWRITE} !== '0) begin
      errors++;
      $display("FAIL reset_bus got htrans=%h haddr=%h hwdata=%h hsize=%h hwrite=%b exp all 0",
               HTRANS, HADDR, HWDATA, HSIZE, HWRITE);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rsp got valid=%b err=%b rdata=%h exp 0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
      errors++;
      $display("FAIL reset_consts got hburst=%h hprot=%h hmastlock=%b exp 0 3 0",
               HBURST, HPROT, HMASTLOCK);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", cmd_ready);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_write_zero_wait();
    HREADY = 1'b1;
    HRESP  = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 32'h4000_0008, 3'd2, 32'h0000_0001);
    @(negedge HCLK);  // T+1
    checks++;
    if ({HTRANS, HWRITE, HADDR, HSIZE, cmd_ready} !== {2'b10, 1'b1, 32'h4000_0008, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL wr_addr_phase got htrans=%h hwrite=%b haddr=%h hsize=%h ready=%b exp 2 1 40000008 2 0",
               HTRANS, HWRITE, HADDR, HSIZE, cmd_ready);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);  // T+2
    checks++;
    if ({HTRANS, HWDATA} !== {2'b00, 32'h0000_0001}) begin
      errors++;
      $display("FAIL wr_data_phase got htrans=%h hwdata=%h exp 0 00000001", HTRANS, HWDATA);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);  // T+3
    checks++;
    if ({rsp_valid, cmd_ready, HTRANS} !== {1'b1, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL wr_rsp_cycle got valid=%b ready=%b htrans=%h exp 1 1 0",
               rsp_valid, cmd_ready, HTRANS);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_read_data_waits();
    HREADY = 1'b1;
    HRDATA = 32'hDEAD_BEEF;
    exp_q.push_back('{rdata: 32'h0000_0001, err: 1'b0});
    issue(1'b0, 32'h4000_0004, 3'd2, 32'h0);
    @(posedge HCLK); #1;  // after T+1, now in data phase
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++;
      if ({cmd_ready, rsp_valid, HTRANS} !== {1'b0, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL rd_wait_%0d got ready=%b valid=%b htrans=%h exp 0 0 0",
                 i, cmd_ready, rsp_valid, HTRANS);
      end
      @(posedge HCLK); #1;
    end
    HREADY = 1'b1;
    HRDATA = 32'h0000_0001;
    @(negedge HCLK);  // T+5
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_last_wait got ready=%b valid=%b exp 0 0", cmd_ready, rsp_valid);
    end
    @(posedge HCLK); #1;
    HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);  // T+6
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rd_rsp_t6 got valid=%b ready=%b exp 1 1", rsp_valid, cmd_ready);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_addr_waits();
    HRDATA = 32'h0;
    exp_q.push_back('{rdata: 32'hA5A5_5A5A, err: 1'b0});
    issue(1'b0, 32'h4000_0020, 3'd2, 32'h0);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++;
      if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h4000_0020, 1'b0}) begin
        errors++;
        $display("FAIL addr_hold_%0d got htrans=%h haddr=%h hwrite=%b exp 2 40000020 0",
                 i, HTRANS, HADDR, HWRITE);
      end
      @(posedge HCLK); #1;
      if (i == 1) HREADY = 1'b1;
    end
    HRDATA = 32'hA5A5_5A5A;
    @(negedge HCLK);  // data phase
    checks++;
    if ({HTRANS, rsp_valid} !== {2'b00, 1'b0}) begin
      errors++;
      $display("FAIL addr_wait_data got htrans=%h valid=%b exp 0 0", HTRANS, rsp_valid);
    end
    @(posedge HCLK); #1;
    HRDATA = 32'h0;
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL addr_wait_rsp got %b exp 1", rsp_valid);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_slave_error();
    HREADY = 1'b1;
    HRDATA = 32'hFFFF_FFFF;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b0, 32'h4000_0030, 3'd2, 32'h0);
    @(posedge HCLK); #1;  // data phase
    HREADY = 1'b0;
    HRESP  = 1'b1;
    @(negedge HCLK);
    checks++;
    if ({HTRANS, rsp_valid} !== 4'b0) begin
      errors++;
      $display("FAIL err_first got htrans=%h valid=%b exp 0 0", HTRANS, rsp_valid);
    end
    @(posedge HCLK); #1;
    HREADY = 1'b1;
    @(negedge HCLK);
    checks++;
    if ({HTRANS, rsp_valid, cmd_ready} !== 4'b0) begin
      errors++;
      $display("FAIL err_second got htrans=%h valid=%b ready=%b exp 0 0 0",
               HTRANS, rsp_valid, cmd_ready);
    end
    @(posedge HCLK); #1;
    HRESP = 1'b0;
    @(negedge HCLK);
    checks++;
    if ({rsp_valid, HTRANS} !== {1'b1, 2'b00}) begin
      errors++;
      $display("FAIL err_rsp got valid=%b htrans=%h exp 1 0", rsp_valid, HTRANS);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if (HTRANS !== 2'b00) begin
      errors++;
      $display("FAIL err_no_retry got htrans=%h exp 0", HTRANS);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs[3];
    logic [2:0]  sizes[3];
    addrs[0] = 32'h4000_0002; sizes[0] = 3'd2;
    addrs[1] = 32'h4000_0000; sizes[1] = 3'd3;
    addrs[2] = 32'h4000_0041; sizes[2] = 3'd1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
      issue(1'b1, addrs[i], sizes[i], 32'h1111_2222);
      @(negedge HCLK);
      checks++;
      if ({HTRANS, rsp_valid, rsp_err, cmd_ready} !== {2'b00, 1'b1, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL misalign_%0d got htrans=%h valid=%b err=%b ready=%b exp 0 1 1 1",
                 i, HTRANS, rsp_valid, rsp_err, cmd_ready);
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    HREADY = 1'b1;
    HRDATA = 32'h1234_5678;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 32'h4000_0012, 3'd1, 32'h0000_BEEF);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if (HWDATA !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL b2b_hwdata got %h exp 0000beef", HWDATA);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);  // rsp cycle of first transfer
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_first_rsp got valid=%b ready=%b exp 1 1", rsp_valid, cmd_ready);
    end
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    issue(1'b0, 32'h4000_0013, 3'd0, 32'h0);
    @(negedge HCLK);
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE} !== {2'b10, 32'h4000_0013, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL b2b_second_addr got htrans=%h haddr=%h hwrite=%b hsize=%h exp 2 40000013 0 0",
               HTRANS, HADDR, HWRITE, HSIZE);
    end
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_rsp got %b exp 1", rsp_valid);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset_mid_transfer();
    HREADY = 1'b1;
    issue(1'b1, 32'h4000_0050, 3'd2, 32'hCAFE_F00D);
    @(posedge HCLK); #1;  // data phase
    HREADY = 1'b0;
    @(posedge HCLK); #2;  // inside a wait state
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({HTRANS, rsp_valid, cmd_ready} !== {2'b00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got htrans=%h valid=%b ready=%b exp 0 0 1",
               HTRANS, rsp_valid, cmd_ready);
    end
    HREADY = 1'b1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 32'h4000_0054, 3'd2, 32'h0000_00AA);
    @(negedge HCLK);
    checks++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h4000_0054}) begin
      errors++;
      $display("FAIL post_reset_addr got htrans=%h haddr=%h exp 2 40000054", HTRANS, HADDR);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if (HWDATA !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL post_reset_hwdata got %h exp 000000aa", HWDATA);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rsp got %b exp 1", rsp_valid);
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    HRDATA    = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_data_waits();
    test_addr_waits();
    test_slave_error();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_transfer();
    repeat (2) @(posedge HCLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_rsp got %0d outstanding exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
